// File: rtl/mult_dp.sv
// Datapath for the repeated-addition multiplier. It holds the operands, accumulates A once
// per iteration, counts iterations and returns lt = (count < B) to the control FSM.
module mult_dp #(
  parameter int W     = 4,
  parameter int ACC_W = 2 * W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W-1:0]     a_in,
  input  logic [W-1:0]     b_in,
  input  logic             load_acc_zero,
  input  logic             load_count,
  input  logic             load_acc,
  input  logic             en_count,
  output logic             lt,
  output logic [ACC_W-1:0] product,
  output logic [W-1:0]     count,
  output logic             ovf
);

  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [W-1:0]     count_q, count_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W:0]   sum;

  // One extra bit on the sum so a carry out of ACC_W can be latched into the sticky flag.
  assign sum = {1'b0, acc_q} + {{(ACC_W + 1 - W){1'b0}}, a_q};

  always_comb begin
    acc_d = acc_q;
    ovf_d = ovf_q;
    if (load_acc_zero) begin
      acc_d = '0;
      ovf_d = 1'b0;
    end else if (load_acc) begin
      acc_d = sum[ACC_W-1:0];
      ovf_d = ovf_q | sum[ACC_W];
    end
  end

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    count_d = count_q;
    if (load_count) begin
      a_d     = a_in;
      b_d     = b_in;
      count_d = '0;
    end else if (en_count) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      count_q <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      count_q <= count_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
    end
  end

  // Loop condition depends on registers only, so the FSM never sees a combinational input path.
  assign lt      = (count_q < b_q);
  assign product = acc_q;
  assign count   = count_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_mult_dp.sv
// Bench for mult_dp: table of strobe/operand vectors with hand-computed results on an
// ACC_W=8 instance, plus sequences for overflow (ACC_W=6 twin) and asynchronous reset.
module tb_mult_dp;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] a_in = '0, b_in = '0;
  logic       load_acc_zero = 1'b0, load_count = 1'b0, load_acc = 1'b0, en_count = 1'b0;

  logic       lt8, ovf8, lt6, ovf6;
  logic [7:0] product8;
  logic [5:0] product6;
  logic [3:0] count8, count6;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic       lz, lc, la, ec;
    logic [3:0] a, b;
    logic [7:0] prod;
    logic [3:0] cnt;
    logic       lt, ovf;
  } vec_t;

  vec_t vecs[$];

  mult_dp #(.W(4), .ACC_W(8)) dut8 (
    .clk(clk), .rst(rst), .a_in(a_in), .b_in(b_in),
    .load_acc_zero(load_acc_zero), .load_count(load_count),
    .load_acc(load_acc), .en_count(en_count),
    .lt(lt8), .product(product8), .count(count8), .ovf(ovf8)
  );

  mult_dp #(.W(4), .ACC_W(6)) dut6 (
    .clk(clk), .rst(rst), .a_in(a_in), .b_in(b_in),
    .load_acc_zero(load_acc_zero), .load_count(load_count),
    .load_acc(load_acc), .en_count(en_count),
    .lt(lt6), .product(product6), .count(count6), .ovf(ovf6)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic lz, input logic lc, input logic la, input logic ec,
                       input logic [3:0] a, input logic [3:0] b);
    @(negedge clk);
    load_acc_zero = lz;
    load_count    = lc;
    load_acc      = la;
    en_count      = ec;
    a_in          = a;
    b_in          = b;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic lz, input logic lc, input logic la, input logic ec,
                     input logic [3:0] a, input logic [3:0] b, input logic [7:0] prod,
                     input logic [3:0] cnt, input logic lt, input logic ovf);
    vec_t v;
    v.lz = lz; v.lc = lc; v.la = la; v.ec = ec; v.a = a; v.b = b;
    v.prod = prod; v.cnt = cnt; v.lt = lt; v.ovf = ovf;
    vecs.push_back(v);
  endtask

  initial begin
    // A=3, B=5: five iterations give 15, lt falls after the fifth
    add(1, 1, 0, 0, 4'd3, 4'd5, 8'd0, 4'd0, 1, 0);
    add(0, 0, 1, 1, 4'd0, 4'd0, 8'd3, 4'd1, 1, 0);
    add(0, 0, 1, 1, 4'd0, 4'd0, 8'd6, 4'd2, 1, 0);
    add(0, 0, 1, 1, 4'd0, 4'd0, 8'd9, 4'd3, 1, 0);
    add(0, 0, 1, 1, 4'd0, 4'd0, 8'd12, 4'd4, 1, 0);
    add(0, 0, 1, 1, 4'd0, 4'd0, 8'd15, 4'd5, 0, 0);
    add(0, 0, 0, 0, 4'd7, 4'd7, 8'd15, 4'd5, 0, 0);
    // A=9, B=0: lt low right after load
    add(1, 1, 0, 0, 4'd9, 4'd0, 8'd0, 4'd0, 0, 0);
    add(0, 0, 0, 0, 4'd0, 4'd0, 8'd0, 4'd0, 0, 0);
    // priority: acc=12/count=3, then clear beats accumulate, load beats increment
    add(1, 1, 0, 0, 4'd4, 4'd6, 8'd0, 4'd0, 1, 0);
    add(0, 0, 1, 1, 4'd0, 4'd0, 8'd4, 4'd1, 1, 0);
    add(0, 0, 1, 1, 4'd0, 4'd0, 8'd8, 4'd2, 1, 0);
    add(0, 0, 1, 1, 4'd0, 4'd0, 8'd12, 4'd3, 1, 0);
    add(1, 0, 1, 0, 4'd0, 4'd0, 8'd0, 4'd3, 1, 0);
    add(0, 1, 0, 1, 4'd4, 4'd6, 8'd0, 4'd0, 1, 0);
    // wrap: A=1, B=15, 15 iterations then one more increment
    add(1, 1, 0, 0, 4'd1, 4'd15, 8'd0, 4'd0, 1, 0);
    for (int i = 1; i <= 15; i++)
      add(0, 0, 1, 1, 4'd0, 4'd0, 8'(i), 4'(i), (i < 15), 0);
    add(0, 0, 0, 1, 4'd0, 4'd0, 8'd15, 4'd0, 1, 0);

    repeat (2) @(posedge clk);
    #1;
    chk("reset_product", product8, 0);
    chk("reset_count", count8, 0);
    chk("reset_lt", lt8, 0);
    chk("reset_ovf", ovf8, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].lz, vecs[i].lc, vecs[i].la, vecs[i].ec, vecs[i].a, vecs[i].b);
      chk($sformatf("vec%0d_product", i), product8, vecs[i].prod);
      chk($sformatf("vec%0d_count", i), count8, vecs[i].cnt);
      chk($sformatf("vec%0d_lt", i), lt8, vecs[i].lt);
      chk($sformatf("vec%0d_ovf", i), ovf8, vecs[i].ovf);
    end

    // 15 x 15 on both widths; the 6-bit accumulator overflows and stays flagged
    drive(1, 1, 0, 0, 4'd15, 4'd15);
    for (int i = 0; i < 20 && lt8; i++)
      drive(0, 0, 1, 1, 4'd0, 4'd0);
    chk("mul15_loop_done", lt8, 0);
    chk("mul15_count", count8, 15);
    chk("mul15_product8", product8, 225);
    chk("mul15_ovf8", ovf8, 0);
    chk("mul15_product6", product6, 33);
    chk("mul15_ovf6", ovf6, 1);
    repeat (3) drive(0, 0, 0, 0, 4'd0, 4'd0);
    chk("ovf6_sticky", ovf6, 1);
    chk("product6_hold", product6, 33);
    drive(1, 0, 0, 0, 4'd0, 4'd0);
    chk("ovf6_cleared", ovf6, 0);
    chk("product6_cleared", product6, 0);

    // asynchronous reset mid-iteration at acc=6, count=2
    drive(1, 1, 0, 0, 4'd3, 4'd5);
    drive(0, 0, 1, 1, 4'd0, 4'd0);
    drive(0, 0, 1, 1, 4'd0, 4'd0);
    chk("pre_rst_product", product8, 6);
    chk("pre_rst_count", count8, 2);
    #1;
    rst = 1'b1;
    load_acc = 1'b0;
    en_count = 1'b0;
    #1;
    chk("async_rst_product", product8, 0);
    chk("async_rst_count", count8, 0);
    chk("async_rst_lt", lt8, 0);
    chk("async_rst_ovf", ovf8, 0);
    @(negedge clk);
    rst = 1'b0;
    drive(1, 1, 0, 0, 4'd2, 4'd3);
    chk("post_rst_lt", lt8, 1);
    for (int i = 0; i < 10 && lt8; i++)
      drive(0, 0, 1, 1, 4'd0, 4'd0);
    chk("post_rst_loop_done", lt8, 0);
    chk("post_rst_product", product8, 6);
    chk("post_rst_count", count8, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
